// File: rtl/factorial_result_reader.sv
// Factorial result reader: snapshots the engine result when op_done rises, streams it
// LSW-first as WORD_W words over valid/ready, then pulses irq and optionally op_clear.
module factorial_result_reader #(
    parameter int unsigned RESULT_W = 128,
    parameter int unsigned WORD_W   = 32,
    localparam int unsigned NUM_WORDS = RESULT_W / WORD_W,
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_done,
    input  logic [RESULT_W-1:0] result,
    input  logic                auto_clear,
    input  logic                rd_ready,
    output logic                rd_valid,
    output logic [WORD_W-1:0]   rd_data,
    output logic [IDX_W-1:0]    rd_index,
    output logic                rd_last,
    output logic                op_clear,
    output logic                irq,
    output logic                busy,
    output logic                missed
);

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_WORDS - 1);

    state_e              state_q, state_d;
    logic [RESULT_W-1:0] buffer_q, buffer_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                done_q;
    logic                missed_q, missed_d;
    logic                rise;

    assign rise = op_done & ~done_q;

    // State, buffer, index, edge-detect and sticky-miss registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            buffer_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buffer_q <= buffer_d;
            idx_q    <= idx_d;
            done_q   <= op_done;
            missed_q <= missed_d;
        end
    end

    // Next-state logic; the buffer only loads on a rise seen in idle so it stays frozen
    // for the whole transfer.
    always_comb begin
        state_d  = state_q;
        buffer_d = buffer_q;
        idx_d    = idx_q;
        missed_d = missed_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    buffer_d = result;
                    idx_d    = '0;
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (rise) missed_d = 1'b1;
                if (rd_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                if (rise) missed_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and registers only; rd_ready never reaches rd_valid.
    always_comb begin
        rd_valid = (state_q == StSend);
        rd_data  = buffer_q[idx_q*WORD_W +: WORD_W];
        rd_index = idx_q;
        rd_last  = rd_valid && (idx_q == LastIdx);
        irq      = (state_q == StDone);
        op_clear = (state_q == StDone) && auto_clear;
        busy     = (state_q != StIdle);
        missed   = missed_q;
    end

endmodule

// File: tb/tb_factorial_result_reader.sv
// Directed bench for factorial_result_reader with immediate-assertion checks.
module tb_factorial_result_reader;

    logic         clk;
    logic         reset;
    logic         op_done;
    logic [127:0] result;
    logic         auto_clear;
    logic         rd_ready;
    logic         rd_valid;
    logic [31:0]  rd_data;
    logic [1:0]   rd_index;
    logic         rd_last;
    logic         op_clear;
    logic         irq;
    logic         busy;
    logic         missed;

    int errors = 0;
    int checks = 0;

    logic [127:0] exp_res;

    factorial_result_reader #(
        .RESULT_W(128),
        .WORD_W  (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op_done   (op_done),
        .result    (result),
        .auto_clear(auto_clear),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_index  (rd_index),
        .rd_last   (rd_last),
        .op_clear  (op_clear),
        .irq       (irq),
        .busy      (busy),
        .missed    (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rd_valid"}, 128'(rd_valid), 128'd0);
        chk({tag, ".rd_data"},  128'(rd_data),  128'd0);
        chk({tag, ".rd_index"}, 128'(rd_index), 128'd0);
        chk({tag, ".rd_last"},  128'(rd_last),  128'd0);
        chk({tag, ".op_clear"}, 128'(op_clear), 128'd0);
        chk({tag, ".irq"},      128'(irq),      128'd0);
        chk({tag, ".busy"},     128'(busy),     128'd0);
        chk({tag, ".missed"},   128'(missed),   128'd0);
    endtask

    initial begin
        reset      = 1'b1;
        op_done    = 1'b0;
        result     = '0;
        auto_clear = 1'b1;
        rd_ready   = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();
        chk("idle.busy", 128'(busy), 128'd0);

        // 1) 5! with back-to-back ready and auto_clear.
        exp_res  = 128'h78;
        result   = exp_res;
        op_done  = 1'b1;
        rd_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t1.valid", 128'(rd_valid), 128'd1);
            chk("t1.data",  128'(rd_data),  128'(exp_res[i*32 +: 32]));
            chk("t1.index", 128'(rd_index), 128'(i));
            chk("t1.last",  128'(rd_last),  128'(i == 3));
            chk("t1.irq_low", 128'(irq), 128'd0);
            tick();
        end
        chk("t1.done_valid", 128'(rd_valid), 128'd0);
        chk("t1.irq",        128'(irq),      128'd1);
        chk("t1.op_clear",   128'(op_clear), 128'd1);
        chk("t1.done_busy",  128'(busy),     128'd1);
        op_done = 1'b0;
        tick();
        chk("t1.irq_pulse",  128'(irq),      128'd0);
        chk("t1.clr_pulse",  128'(op_clear), 128'd0);
        chk("t1.idle_busy",  128'(busy),     128'd0);

        // 2) Words 4,3,2,1 with a stall before every acceptance.
        exp_res  = {32'h1, 32'h2, 32'h3, 32'h4};
        result   = exp_res;
        op_done  = 1'b1;
        rd_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2.data",  128'(rd_data),  128'(exp_res[i*32 +: 32]));
            rd_ready = 1'b0;
            tick();
            chk("t2.hold_data",  128'(rd_data),  128'(exp_res[i*32 +: 32]));
            chk("t2.hold_index", 128'(rd_index), 128'(i));
            chk("t2.hold_valid", 128'(rd_valid), 128'd1);
            rd_ready = 1'b1;
            tick();
        end
        chk("t2.irq",      128'(irq),      128'd1);
        chk("t2.op_clear", 128'(op_clear), 128'd1);
        op_done = 1'b0;
        tick();

        // 3) auto_clear=0 with op_done left high: no clear, no retrigger.
        auto_clear = 1'b0;
        exp_res    = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
        result     = exp_res;
        op_done    = 1'b1;
        rd_ready   = 1'b1;
        tick();
        repeat (4) tick();
        chk("t3.irq",      128'(irq),      128'd1);
        chk("t3.op_clear", 128'(op_clear), 128'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3.no_retrig_valid", 128'(rd_valid), 128'd0);
            chk("t3.no_retrig_busy",  128'(busy),     128'd0);
        end
        op_done = 1'b0;
        tick();
        chk("t3.low_idle", 128'(busy), 128'd0);
        op_done  = 1'b1;
        rd_ready = 1'b0;
        tick();
        chk("t3.retrig_valid", 128'(rd_valid), 128'd1);
        chk("t3.retrig_data",  128'(rd_data),  128'(exp_res[31:0]));

        // 4) New result plus a fresh rise during SEND: frozen buffer, sticky missed.
        result  = ~exp_res;
        op_done = 1'b0;
        tick();
        chk("t4.missed_before", 128'(missed), 128'd0);
        op_done = 1'b1;
        tick();
        chk("t4.missed",      128'(missed),   128'd1);
        chk("t4.data_frozen", 128'(rd_data),  128'(exp_res[31:0]));
        rd_ready = 1'b1;
        tick();
        chk("t4.word1", 128'(rd_data), 128'(exp_res[63:32]));
        tick();
        rd_ready = 1'b0;
        tick();
        chk("t4.word2",         128'(rd_data),  128'(exp_res[95:64]));
        chk("t4.idx2",          128'(rd_index), 128'd2);
        chk("t4.missed_sticky", 128'(missed),   128'd1);

        // 5) Reset mid-transfer at idx=2: everything clears, no irq/op_clear afterwards.
        auto_clear = 1'b1;
        rd_ready   = 1'b1;
        reset      = 1'b1;
        tick();
        chk_all_zero("t5.reset");
        reset   = 1'b0;
        op_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5.no_irq",   128'(irq),      128'd0);
            chk("t5.no_clear", 128'(op_clear), 128'd0);
            chk("t5.idle",     128'(busy),     128'd0);
        end

        // 6) op_done held through reset: capture on the first edge after release.
        exp_res = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        result  = exp_res;
        op_done = 1'b1;
        reset   = 1'b1;
        tick();
        tick();
        chk("t6.reset_busy",  128'(busy),     128'd0);
        chk("t6.reset_valid", 128'(rd_valid), 128'd0);
        reset = 1'b0;
        tick();
        chk("t6.valid", 128'(rd_valid), 128'd1);
        chk("t6.data",  128'(rd_data),  128'(exp_res[31:0]));
        repeat (3) tick();
        chk("t6.last_data", 128'(rd_data), 128'(exp_res[127:96]));
        chk("t6.last",      128'(rd_last), 128'd1);
        tick();
        chk("t6.irq",      128'(irq),      128'd1);
        chk("t6.op_clear", 128'(op_clear), 128'd1);
        tick();
        chk("t6.end_idle", 128'(busy), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
